// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the datapath microcontroller: instruction field layout,
// opcodes and FSM state encoding.
package datapath_ctrl_pkg;

    localparam int INSTR_W = 15;
    localparam int STEP_W  = 8;

    localparam int IMM_LSB   = 0;
    localparam int IMM_W     = 4;
    localparam int OPSEL_LSB = 4;
    localparam int OPSEL_W   = 2;
    localparam int EN_X_BIT  = 6;
    localparam int EN_Y_BIT  = 7;
    localparam int Y_SEL_BIT = 8;
    localparam int OPC_LSB   = 9;
    localparam int OPC_W     = 2;
    localparam int TGT_LSB   = 11;
    localparam int TGT_W     = 4;

    localparam logic [OPC_W-1:0] OP_NEXT = 2'b00;
    localparam logic [OPC_W-1:0] OP_JUMP = 2'b01;
    localparam logic [OPC_W-1:0] OP_BZ   = 2'b10;
    localparam logic [OPC_W-1:0] OP_HALT = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/ctrl_ram.sv
// Program store: synchronous write, asynchronous read so the current pc's word
// drives the datapath in the same cycle. Contents are deliberately not reset.
module ctrl_ram
    import datapath_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = INSTR_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/datapath_ctrl.sv
// Start/done sequenced microprogram controller driving the 4-bit datapath's
// control inputs from a writable program store, with zero-flag branches.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int MAX_STEPS = 255,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic               zero,
    output logic [IMM_W-1:0]   imm,
    output logic [OPSEL_W-1:0] op_sel,
    output logic               en_x,
    output logic               en_y,
    output logic               y_sel,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [AW-1:0]      pc
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

    state_t              state_reg, state_next;
    logic [AW-1:0]       pc_reg, pc_next;
    logic [STEP_W-1:0]   step_reg, step_next;
    logic                err_reg, err_next;

    logic [INSTR_W-1:0]  instr;
    logic [OPC_W-1:0]    opcode;
    logic [AW-1:0]       target;
    logic [AW-1:0]       pc_inc;
    logic                run;

    assign run    = (state_reg == ST_RUN);
    assign opcode = instr[OPC_LSB +: OPC_W];
    assign target = AW'(instr[TGT_LSB +: TGT_W]);
    assign pc_inc = pc_reg + AW'(1);

    // The program store is writable whenever the sequencer is not executing.
    ctrl_ram #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (prog_we & ~run),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_reg),
        .rdata (instr)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        step_next  = step_reg;
        err_next   = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    pc_next    = '0;
                    step_next  = '0;
                    err_next   = 1'b0;
                end
            end
            ST_RUN: begin
                step_next = step_reg + STEP_W'(1);
                if (opcode == OP_HALT) begin
                    state_next = ST_DONE;
                end else if (step_reg == LAST_STEP) begin
                    // Runaway program: this word still executed, but stop here.
                    state_next = ST_DONE;
                    err_next   = 1'b1;
                end else begin
                    case (opcode)
                        OP_JUMP: pc_next = target;
                        OP_BZ:   pc_next = zero ? target : pc_inc;
                        default: pc_next = pc_inc;
                    endcase
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            step_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            step_reg  <= step_next;
            err_reg   <= err_next;
        end
    end

    assign imm    = run ? instr[IMM_LSB +: IMM_W]     : '0;
    assign op_sel = run ? instr[OPSEL_LSB +: OPSEL_W] : '0;
    assign en_x   = run & instr[EN_X_BIT];
    assign en_y   = run & instr[EN_Y_BIT];
    assign y_sel  = run & instr[Y_SEL_BIT];
    assign busy   = run;
    assign done   = (state_reg == ST_DONE);
    assign err    = err_reg;
    assign pc     = pc_reg;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl: a per-cycle vector table followed by
// hand-written abort and mid-run reset sequences.
module tb_datapath_ctrl;
    import datapath_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [14:0] prog_data;
    logic        start;
    logic        zero;
    logic [3:0]  imm;
    logic [1:0]  op_sel;
    logic        en_x;
    logic        en_y;
    logic        y_sel;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  pc;

    int n_vec  = 0;
    int n_miss = 0;

    datapath_ctrl #(.DEPTH(16), .MAX_STEPS(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .zero      (zero),
        .imm       (imm),
        .op_sel    (op_sel),
        .en_x      (en_x),
        .en_y      (en_y),
        .y_sel     (y_sel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pc        (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        zero;
        logic        we;
        logic [3:0]  addr;
        logic [14:0] data;
        logic        busy;
        logic        done;
        logic        err;
        logic [3:0]  pc;
        logic [8:0]  ctrl;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [14:0] ins(input logic [1:0] opc, input logic [3:0] tgt,
                                        input logic [8:0] c);
        return {tgt, opc, c};
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic z, input logic w,
                                input logic [3:0] a, input logic [14:0] d,
                                input logic b, input logic dn, input logic e,
                                input logic [3:0] p, input logic [8:0] c);
        vec_t v;
        v.rst_n = r; v.start = s; v.zero = z; v.we = w; v.addr = a; v.data = d;
        v.busy = b; v.done = dn; v.err = e; v.pc = p; v.ctrl = c;
        return v;
    endfunction

    function automatic logic [8:0] fw(input int i);
        return 9'((i * 41 + 7) % 512);
    endfunction

    function automatic logic [8:0] ctrl_now();
        return {y_sel, en_y, en_x, op_sel, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic write_word(input logic [3:0] a, input logic [14:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        logic ctrl_ok;

        rst_n = 1'b0; start = 1'b0; zero = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;

        //        rst start zero we addr data                      busy done err pc ctrl
        // reset and basic NEXT/HALT program
        vecs.push_back(mk(0, 0, 0, 0, 0, 15'h0,                      0, 0, 0, 0,  9'h000));
        vecs.push_back(mk(1, 0, 0, 1, 0, ins(OP_NEXT, 0, 9'h185),    0, 0, 0, 0,  9'h000));
        vecs.push_back(mk(1, 0, 0, 1, 1, ins(OP_HALT, 0, 9'h000),    0, 0, 0, 0,  9'h000));
        vecs.push_back(mk(1, 1, 0, 0, 0, 15'h0,                      1, 0, 0, 0,  9'h185));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      1, 0, 0, 1,  9'h000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 1, 0, 1,  9'h000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 0, 0, 1,  9'h000));
        // BZ taken then not taken; zero only matters in the BZ cycle
        vecs.push_back(mk(1, 0, 0, 1, 0, ins(OP_BZ, 7, 9'h051),      0, 0, 0, 1,  9'h000));
        vecs.push_back(mk(1, 0, 0, 1, 7, ins(OP_HALT, 0, 9'h002),    0, 0, 0, 1,  9'h000));
        vecs.push_back(mk(1, 1, 0, 0, 0, 15'h0,                      1, 0, 0, 0,  9'h051));
        vecs.push_back(mk(1, 0, 1, 0, 0, 15'h0,                      1, 0, 0, 7,  9'h002));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 1, 0, 7,  9'h000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 0, 0, 7,  9'h000));
        vecs.push_back(mk(1, 1, 1, 0, 0, 15'h0,                      1, 0, 0, 0,  9'h051));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      1, 0, 0, 1,  9'h000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 1, 0, 1,  9'h000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 0, 0, 1,  9'h000));
        // write while busy is ignored
        vecs.push_back(mk(1, 0, 0, 1, 0, ins(OP_NEXT, 0, 9'h185),    0, 0, 0, 1,  9'h000));
        vecs.push_back(mk(1, 1, 0, 0, 0, 15'h0,                      1, 0, 0, 0,  9'h185));
        vecs.push_back(mk(1, 0, 0, 1, 0, 15'h7FFF,                   1, 0, 0, 1,  9'h000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 1, 0, 1,  9'h000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 0, 0, 1,  9'h000));
        vecs.push_back(mk(1, 1, 0, 0, 0, 15'h0,                      1, 0, 0, 0,  9'h185));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      1, 0, 0, 1,  9'h000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 1, 0, 1,  9'h000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 0, 0, 1,  9'h000));
        // write plus start in IDLE: the run sees the new (HALT) word
        vecs.push_back(mk(1, 1, 0, 1, 0, 15'h7FFF,                   1, 0, 0, 0,  9'h1FF));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 1, 0, 0,  9'h000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 0, 0, 0,  9'h000));
        // start held high: ignored in DONE, relaunches from IDLE
        vecs.push_back(mk(1, 1, 0, 0, 0, 15'h0,                      1, 0, 0, 0,  9'h1FF));
        vecs.push_back(mk(1, 1, 0, 0, 0, 15'h0,                      0, 1, 0, 0,  9'h000));
        vecs.push_back(mk(1, 1, 0, 0, 0, 15'h0,                      0, 0, 0, 0,  9'h000));
        vecs.push_back(mk(1, 1, 0, 0, 0, 15'h0,                      1, 0, 0, 0,  9'h1FF));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 1, 0, 0,  9'h000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 0, 0, 0,  9'h000));
        // pc wrap 15 -> 0: BZ to 15, NEXT at 15, BZ falls through to HALT at 1
        vecs.push_back(mk(1, 0, 0, 1, 0, ins(OP_BZ, 15, 9'h021),     0, 0, 0, 0,  9'h000));
        vecs.push_back(mk(1, 0, 0, 1, 15, ins(OP_NEXT, 0, 9'h03C),   0, 0, 0, 0,  9'h000));
        vecs.push_back(mk(1, 1, 0, 0, 0, 15'h0,                      1, 0, 0, 0,  9'h021));
        vecs.push_back(mk(1, 0, 1, 0, 0, 15'h0,                      1, 0, 0, 15, 9'h03C));
        vecs.push_back(mk(1, 0, 1, 0, 0, 15'h0,                      1, 0, 0, 0,  9'h021));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      1, 0, 0, 1,  9'h000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 1, 0, 1,  9'h000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15'h0,                      0, 0, 0, 1,  9'h000));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n     = vecs[i].rst_n;
            start     = vecs[i].start;
            zero      = vecs[i].zero;
            prog_we   = vecs[i].we;
            prog_addr = vecs[i].addr;
            prog_data = vecs[i].data;
            tick();
            chk($sformatf("vec%0d {busy,done,err,pc,ctrl}", i),
                32'({busy, done, err, pc, ctrl_now()}),
                32'({vecs[i].busy, vecs[i].done, vecs[i].err, vecs[i].pc, vecs[i].ctrl}));
        end
        start = 1'b0; zero = 1'b0; prog_we = 1'b0;

        // Runaway loop: JUMP 0 forever must abort after 255 busy cycles.
        write_word(4'd0, ins(OP_JUMP, 0, 9'h0C0));
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = 0;
        ctrl_ok  = 1'b1;
        for (int c = 0; c < 400 && busy === 1'b1; c++) begin
            busy_cnt++;
            if (ctrl_now() !== 9'h0C0 || pc !== 4'd0) ctrl_ok = 1'b0;
            tick();
        end
        chk("abort_busy_cycles", 32'(busy_cnt), 32'd255);
        chk("abort_ctrl_each_cycle", 32'(ctrl_ok), 32'd1);
        chk("abort_done_err", 32'({busy, done, err, ctrl_now()}), 32'({1'b0, 1'b1, 1'b1, 9'h000}));
        tick();
        chk("err_holds_in_idle", 32'({busy, done, err}), 32'b001);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = ins(OP_HALT, 0, 9'h000);
        start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        chk("err_clears_on_start", 32'({busy, err}), 32'b10);
        tick();
        tick();

        // Reset in cycle 3 of a 10-instruction program, then an identical rerun.
        for (int i = 0; i < 10; i++) begin
            write_word(4'(i), ins((i == 9) ? OP_HALT : OP_NEXT, 0, fw(i)));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("prerst_cycle%0d", i + 1), 32'({busy, pc, ctrl_now()}),
                32'({1'b1, 4'(i), fw(i)}));
            if (i < 2) tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrun_reset", 32'({busy, done, err, pc, ctrl_now()}), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("rerun_pc%0d", i), 32'({busy, pc, ctrl_now()}),
                32'({1'b1, 4'(i), fw(i)}));
            tick();
        end
        chk("rerun_done", 32'({busy, done, err, ctrl_now()}), 32'({1'b0, 1'b1, 1'b0, 9'h000}));
        tick();
        chk("rerun_idle", 32'({busy, done, err}), 32'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
